// File: rtl/timer_sequencer.sv
// Control FSM for the microwave countdown timer: keypad entry, counter-chain
// load/clear, per-second decrement enables, magnetron and done control.
module timer_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        door_closed,
  input  logic        cnt_zero,
  output logic [11:0] cnt_data,
  output logic        cnt_loadn,
  output logic        cnt_clrn,
  output logic        cnt_enable,
  output logic        mag_on,
  output logic        done,
  output logic [2:0]  state
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   entry_q, entry_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          door_q;
  logic          clr_ev;
  logic          enable_d;
  logic          digit_ok;
  logic          door_fall;

  assign digit_ok  = key_valid && (key_digit <= 4'd9);
  assign door_fall = door_q && !door_closed;

  // State register
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, entry register and prescaler updates
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    presc_d  = presc_q;
    clr_ev   = 1'b0;
    enable_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      entry_d = '0;
      presc_d = '0;
      clr_ev  = 1'b1;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          if (start) begin
            // start is only honoured from ENTRY with a shut door and nonzero entry
            if (state_q == ENTRY && door_closed && (entry_q != 12'd0)) begin
              state_d = LOAD;
              presc_d = '0;
              entry_d = {entry_q[11:8],
                         (entry_q[7:4] > 4'd5) ? 4'd5 : entry_q[7:4],
                         entry_q[3:0]};
            end
          end else if (!stop && digit_ok) begin
            state_d = ENTRY;
            entry_d = {entry_q[7:0], key_digit};
          end
        end
        LOAD: begin
          state_d = COOK;
          presc_d = '0;
        end
        COOK: begin
          // leaving COOK freezes the prescaler so a resume continues the second
          if (!door_closed || stop) begin
            state_d = PAUSE;
          end else if (cnt_zero) begin
            state_d = DONE;
            presc_d = '0;
          end else if (presc_q == TERM) begin
            presc_d  = '0;
            enable_d = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (stop) begin
            state_d = IDLE;
            entry_d = '0;
            presc_d = '0;
            clr_ev  = 1'b1;
          end else if (start && door_closed) begin
            state_d = COOK;
          end
        end
        DONE: begin
          if (key_valid || start || stop || door_fall) begin
            state_d = IDLE;
            entry_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          entry_d = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  // Datapath and registered Moore outputs
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      entry_q    <= '0;
      presc_q    <= '0;
      door_q     <= 1'b0;
      cnt_loadn  <= 1'b1;
      cnt_clrn   <= 1'b1;
      cnt_enable <= 1'b0;
      mag_on     <= 1'b0;
      done       <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      presc_q    <= presc_d;
      door_q     <= door_closed;
      cnt_loadn  <= (state_d != LOAD);
      cnt_clrn   <= !clr_ev;
      cnt_enable <= enable_d;
      mag_on     <= (state_d == COOK);
      done       <= (state_d == DONE);
    end
  end

  assign cnt_data = entry_q;
  assign state    = state_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a BCD down-counter chain model.
module tb_timer_sequencer;

  localparam int unsigned TPS = 4;

  logic        clock = 1'b0;
  logic        clrn = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        door_closed = 1'b1;
  logic        cnt_zero;
  logic [11:0] cnt_data;
  logic        cnt_loadn, cnt_clrn, cnt_enable, mag_on, done;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0, n_en;
  int en_t[8];

  logic [3:0] m_so, m_st, m_mo;

  timer_sequencer #(.TICKS_PER_SEC(TPS)) dut (
    .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .cnt_zero(cnt_zero), .cnt_data(cnt_data), .cnt_loadn(cnt_loadn),
    .cnt_clrn(cnt_clrn), .cnt_enable(cnt_enable), .mag_on(mag_on),
    .done(done), .state(state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Cascaded BCD down-counter chain driven by the sequencer
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      m_so <= 4'd0; m_st <= 4'd0; m_mo <= 4'd0;
    end else if (!cnt_clrn) begin
      m_so <= 4'd0; m_st <= 4'd0; m_mo <= 4'd0;
    end else if (!cnt_loadn) begin
      m_mo <= cnt_data[11:8]; m_st <= cnt_data[7:4]; m_so <= cnt_data[3:0];
    end else if (cnt_enable) begin
      if (m_so != 4'd0) m_so <= m_so - 4'd1;
      else begin
        m_so <= 4'd9;
        if (m_st != 4'd0) m_st <= m_st - 4'd1;
        else begin
          m_st <= 4'd5;
          m_mo <= m_mo - 4'd1;
        end
      end
    end
  end
  assign cnt_zero = (m_so == 4'd0) && (m_st == 4'd0) && (m_mo == 4'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    tick();
    key_valid = 1'b0; key_digit = 4'd0;
  endtask

  task automatic pulse_start;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  // Ticks until cnt_enable is seen; returns cycles elapsed or -1 on timeout
  task automatic wait_enable(output int dt);
    int ts;
    ts = cyc;
    dt = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cnt_enable) begin
        dt = cyc - ts;
        break;
      end
    end
  endtask

  initial begin
    int dt;
    // Reset values
    #1 clrn = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_data", 32'(cnt_data), 32'h000);
    check("rst_loadn", 32'(cnt_loadn), 32'd1);
    check("rst_clrn", 32'(cnt_clrn), 32'd1);
    check("rst_en", 32'(cnt_enable), 32'd0);
    check("rst_mag", 32'(mag_on), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #3 clrn = 1'b1;
    tick(2);

    // Entry 1,2,3 then an out-of-range key
    key(4'd1);
    check("entry1_data", 32'(cnt_data), 32'h001);
    check("entry1_state", 32'(state), 32'd1);
    key(4'd2);
    key(4'd3);
    key(4'd12);
    check("entry_data", 32'(cnt_data), 32'h123);
    check("entry_state", 32'(state), 32'd1);
    pulse_start();
    check("load_loadn", 32'(cnt_loadn), 32'd0);
    check("load_state", 32'(state), 32'd2);
    check("load_mag", 32'(mag_on), 32'd0);
    tick();
    check("cook_loadn", 32'(cnt_loadn), 32'd1);
    check("cook_mag", 32'(mag_on), 32'd1);
    check("model_loaded", 32'({m_mo, m_st, m_so}), 32'h123);
    tick(2);
    pulse_clear();
    check("clr_state", 32'(state), 32'd0);
    check("clr_pulse", 32'(cnt_clrn), 32'd0);
    check("clr_mag", 32'(mag_on), 32'd0);
    check("clr_data", 32'(cnt_data), 32'h000);
    tick();
    check("clr_release", 32'(cnt_clrn), 32'd1);

    // Countdown from 0:03
    key(4'd3);
    pulse_start();
    tick();
    check("cd_cook", 32'(state), 32'd3);
    t0 = cyc;
    n_en = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (cnt_enable) begin
        if (n_en < 8) en_t[n_en] = cyc - t0;
        n_en++;
      end
    end
    check("cd_done", 32'(done), 32'd1);
    check("cd_done_time", 32'(cyc - t0), 32'd14);
    check("cd_n_en", 32'(n_en), 32'd3);
    check("cd_en0", 32'(en_t[0]), 32'd4);
    check("cd_en1", 32'(en_t[1]), 32'd8);
    check("cd_en2", 32'(en_t[2]), 32'd12);
    check("cd_mag_off", 32'(mag_on), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cnt_enable) n_en++;
    end
    check("cd_no_extra_en", 32'(n_en), 32'd3);
    check("cd_model_zero", 32'({m_mo, m_st, m_so}), 32'h000);
    check("cd_done_held", 32'(done), 32'd1);
    key(4'd5);
    check("done_exit_state", 32'(state), 32'd0);
    check("done_exit_data", 32'(cnt_data), 32'h000);
    check("done_exit_done", 32'(done), 32'd0);

    // Pause on door open, resume keeps the partial second
    key(4'd3);
    pulse_start();
    tick();
    wait_enable(dt);
    check("pz_first_en", 32'(dt), 32'd4);
    tick();
    door_closed = 1'b0;
    tick();
    check("pz_state", 32'(state), 32'd4);
    check("pz_mag", 32'(mag_on), 32'd0);
    pulse_start();
    check("pz_open_start", 32'(state), 32'd4);
    tick(2);
    door_closed = 1'b1;
    tick();
    pulse_start();
    check("pz_resume", 32'(state), 32'd3);
    check("pz_resume_mag", 32'(mag_on), 32'd1);
    wait_enable(dt);
    check("pz_resume_en", 32'(dt), 32'd3);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("stopstart_cook", 32'(state), 32'd4);
    pulse_stop();
    check("pz_stop_state", 32'(state), 32'd0);
    check("pz_stop_clrn", 32'(cnt_clrn), 32'd0);
    check("pz_stop_data", 32'(cnt_data), 32'h000);
    tick();

    // Guards and clamp
    pulse_start();
    check("idle_start", 32'(state), 32'd0);
    key(4'd0);
    check("zero_entry_state", 32'(state), 32'd1);
    pulse_start();
    check("zero_start_state", 32'(state), 32'd1);
    check("zero_start_loadn", 32'(cnt_loadn), 32'd1);
    key(4'd7);
    key(4'd9);
    check("e79_data", 32'(cnt_data), 32'h079);
    door_closed = 1'b0;
    pulse_start();
    check("open_start_state", 32'(state), 32'd1);
    check("open_start_loadn", 32'(cnt_loadn), 32'd1);
    door_closed = 1'b1;
    pulse_start();
    check("clamp_loadn", 32'(cnt_loadn), 32'd0);
    check("clamp_data", 32'(cnt_data), 32'h059);
    tick();
    pulse_clear();
    tick();

    // clear beats start in ENTRY
    key(4'd4);
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("clrstart_state", 32'(state), 32'd0);
    check("clrstart_clrn", 32'(cnt_clrn), 32'd0);
    check("clrstart_loadn", 32'(cnt_loadn), 32'd1);
    tick();
    check("clrstart_clrn_hi", 32'(cnt_clrn), 32'd1);
    check("clrstart_idle", 32'(state), 32'd0);

    // Asynchronous reset mid-COOK
    key(4'd5);
    pulse_start();
    tick(3);
    check("pre_rst_mag", 32'(mag_on), 32'd1);
    #2 clrn = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_mag", 32'(mag_on), 32'd0);
    check("arst_data", 32'(cnt_data), 32'h000);
    check("arst_loadn", 32'(cnt_loadn), 32'd1);
    check("arst_en", 32'(cnt_enable), 32'd0);
    #2 clrn = 1'b1;
    tick(2);
    check("post_rst_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
